// File: rtl/ysyx_24090012_issue_scoreboard.sv
// In-order issue scoreboard: tracks in-flight {rd, rd_wen, csr_wen} and blocks RAW/CSR hazards; optional stall counters under YSYX_24090012_SCB_PERF_EN.
// Latency: iss_ready/stall_* are combinational from inputs and registered state; tracking updates on the next rising edge.
// Backpressure: iss_ready drops on flush, full FIFO (unless a retire frees a slot) or a live hazard.
module ysyx_24090012_issue_scoreboard #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iss_valid,
  output logic                     iss_ready,
  input  logic [4:0]               iss_rs1,
  input  logic [4:0]               iss_rs2,
  input  logic                     iss_rs1_en,
  input  logic                     iss_rs2_en,
  input  logic [4:0]               iss_rd,
  input  logic                     iss_rd_wen,
  input  logic                     iss_csr_rd,
  input  logic                     iss_csr_wen,
  input  logic                     wb_valid,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   inflight_cnt,
  output logic                     stall_data,
  output logic                     stall_full,
  output logic                     wb_underflow,
  output logic [31:0]              perf_data_stalls,
  output logic [31:0]              perf_full_stalls
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] ent_rd_wen_q, ent_rd_wen_d;
  logic [DEPTH-1:0] ent_csr_wen_q, ent_csr_wen_d;
  logic [4:0]       ent_rd_q [DEPTH];
  logic [4:0]       ent_rd_d [DEPTH];
  logic             underflow_q, underflow_d;

  logic [DEPTH-1:0] live;
  logic             gpr_haz;
  logic             csr_haz;
  logic             hazard;
  logic             full;
  logic             fire;
  logic             pop;

  // The head entry retiring this cycle no longer blocks a dependent offer.
  always_comb begin
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = vld_q[i] && !(wb_valid && (AW'(i) == rd_ptr_q));
    end
  end

  always_comb begin
    gpr_haz = 1'b0;
    csr_haz = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && ent_rd_wen_q[i] && (ent_rd_q[i] != 5'd0) &&
          ((iss_rs1_en && (ent_rd_q[i] == iss_rs1)) ||
           (iss_rs2_en && (ent_rd_q[i] == iss_rs2)))) begin
        gpr_haz = 1'b1;
      end
      if (live[i] && ent_csr_wen_q[i] && (iss_csr_rd || iss_csr_wen)) begin
        csr_haz = 1'b1;
      end
    end
  end

  assign hazard     = gpr_haz || csr_haz;
  assign full       = (count_q == CW'(DEPTH));
  assign stall_full = full && !wb_valid;
  assign iss_ready  = !flush && !stall_full && !hazard;
  assign stall_data = iss_valid && hazard && !flush;
  assign fire       = iss_valid && iss_ready;
  assign pop        = wb_valid && (count_q != '0);

  assign inflight_cnt = count_q;
  assign wb_underflow = underflow_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    vld_d         = vld_q;
    ent_rd_wen_d  = ent_rd_wen_q;
    ent_csr_wen_d = ent_csr_wen_q;
    ent_rd_d      = ent_rd_q;
    underflow_d   = underflow_q || (wb_valid && (count_q == '0));

    // Clear before set: when full, a same-cycle push lands in the slot being freed.
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (fire) begin
      vld_d[wr_ptr_q]         = 1'b1;
      ent_rd_d[wr_ptr_q]      = iss_rd;
      ent_rd_wen_d[wr_ptr_q]  = iss_rd_wen;
      ent_csr_wen_d[wr_ptr_q] = iss_csr_wen;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    count_d = count_q + {{AW{1'b0}}, fire} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      vld_q         <= '0;
      ent_rd_wen_q  <= '0;
      ent_csr_wen_q <= '0;
      underflow_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd_q[i] <= 5'd0;
      end
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      vld_q         <= vld_d;
      ent_rd_wen_q  <= ent_rd_wen_d;
      ent_csr_wen_q <= ent_csr_wen_d;
      underflow_q   <= underflow_d;
      ent_rd_q      <= ent_rd_d;
    end
  end

`ifdef YSYX_24090012_SCB_PERF_EN
  logic [31:0] perf_data_q, perf_data_d;
  logic [31:0] perf_full_q, perf_full_d;

  always_comb begin
    perf_data_d = perf_data_q + {31'd0, stall_data};
    perf_full_d = perf_full_q + {31'd0, (iss_valid && stall_full && !flush)};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_data_q <= 32'd0;
      perf_full_q <= 32'd0;
    end else begin
      perf_data_q <= perf_data_d;
      perf_full_q <= perf_full_d;
    end
  end

  assign perf_data_stalls = perf_data_q;
  assign perf_full_stalls = perf_full_q;
`else
  assign perf_data_stalls = 32'd0;
  assign perf_full_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_24090012_issue_scoreboard.sv
// Scoreboard bench: driver pushes model-predicted outputs per cycle, monitor pops and compares DUT outputs.
module tb_ysyx_24090012_issue_scoreboard;

  localparam int DEPTH = 4;
`ifdef YSYX_24090012_SCB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_rs1_en, iss_rs2_en, iss_rd_wen, iss_csr_rd, iss_csr_wen;
  logic        wb_valid, flush;
  logic [2:0]  inflight_cnt;
  logic        stall_data, stall_full, wb_underflow;
  logic [31:0] perf_data_stalls, perf_full_stalls;

  always #5 clock = ~clock;

  ysyx_24090012_issue_scoreboard #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rs1_en(iss_rs1_en), .iss_rs2_en(iss_rs2_en),
    .iss_rd(iss_rd), .iss_rd_wen(iss_rd_wen),
    .iss_csr_rd(iss_csr_rd), .iss_csr_wen(iss_csr_wen),
    .wb_valid(wb_valid), .flush(flush),
    .inflight_cnt(inflight_cnt), .stall_data(stall_data),
    .stall_full(stall_full), .wb_underflow(wb_underflow),
    .perf_data_stalls(perf_data_stalls), .perf_full_stalls(perf_full_stalls)
  );

  typedef struct {
    logic [4:0] rd;
    logic       rd_wen;
    logic       csr_wen;
  } ent_t;

  typedef struct {
    bit          ready;
    bit          sdata;
    bit          sfull;
    int          cnt;
    bit          uf;
    logic [31:0] pd;
    logic [31:0] pf;
  } exp_t;

  ent_t        m_q[$];
  exp_t        exp_q[$];
  bit          m_uf;
  logic [31:0] m_pd, m_pf;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Reference: any older instruction still in flight (head excused when it retires now)
  // that writes a register or CSR this offer reads.
  function automatic bit model_hazard();
    int first = (wb_valid && m_q.size() > 0) ? 1 : 0;
    for (int i = first; i < m_q.size(); i++) begin
      if (m_q[i].rd_wen && m_q[i].rd != 5'd0 &&
          ((iss_rs1_en && m_q[i].rd == iss_rs1) || (iss_rs2_en && m_q[i].rd == iss_rs2)))
        return 1'b1;
      if ((iss_csr_rd || iss_csr_wen) && m_q[i].csr_wen)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic clr();
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rs1_en = 0; iss_rs2_en = 0;
    iss_rd = 0; iss_rd_wen = 0; iss_csr_rd = 0; iss_csr_wen = 0;
    wb_valid = 0; flush = 0;
  endtask

  task automatic go();
    exp_t e;
    bit   haz, fullst;
    @(negedge clock);
    if (reset) begin
      m_q.delete();
      m_uf = 0; m_pd = 0; m_pf = 0;
    end
    haz    = model_hazard();
    fullst = (m_q.size() == DEPTH) && !wb_valid;
    e.ready = !flush && !fullst && !haz;
    e.sdata = iss_valid && haz && !flush;
    e.sfull = fullst;
    e.cnt   = m_q.size();
    e.uf    = m_uf;
    e.pd    = PERF ? m_pd : 32'd0;
    e.pf    = PERF ? m_pf : 32'd0;
    exp_q.push_back(e);
    if (!reset) begin
      if (wb_valid) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_uf = 1;
      end
      if (iss_valid && e.ready) begin
        ent_t n;
        n.rd = iss_rd; n.rd_wen = iss_rd_wen; n.csr_wen = iss_csr_wen;
        m_q.push_back(n);
      end
      m_pd = m_pd + (e.sdata ? 32'd1 : 32'd0);
      m_pf = m_pf + ((iss_valid && fullst && !flush) ? 32'd1 : 32'd0);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic wen, input logic csrw);
    clr();
    iss_valid = 1; iss_rd = rd; iss_rd_wen = wen; iss_csr_wen = csrw;
    go();
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 1 && m_q.size() > 0; k++) begin
      clr(); wb_valid = 1; go();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("iss_ready",    iss_ready,        e.ready);
        chk("stall_data",   stall_data,       e.sdata);
        chk("stall_full",   stall_full,       e.sfull);
        chk("inflight_cnt", inflight_cnt,     e.cnt);
        chk("wb_underflow", wb_underflow,     e.uf);
        chk("perf_data",    perf_data_stalls, e.pd);
        chk("perf_full",    perf_full_stalls, e.pf);
      end
    end
  end

  initial begin : driver
    clr();
    reset = 1; go(); go();
    reset = 0;

    // RAW on x5 held until retire; released in the retiring cycle
    issue(5'd5, 1, 0);
    for (int k = 0; k < 3; k++) begin clr(); iss_valid = 1; iss_rs1 = 5; iss_rs1_en = 1; go(); end
    clr(); iss_valid = 1; iss_rs1 = 5; iss_rs1_en = 1; wb_valid = 1; go();
    drain();

    // x0 never hazards; a disabled source never hazards
    issue(5'd0, 1, 0);
    clr(); iss_valid = 1; iss_rs1 = 0; iss_rs1_en = 1; go();
    issue(5'd7, 1, 0);
    clr(); iss_valid = 1; iss_rs2 = 7; iss_rs2_en = 0; go();
    drain();

    // Fill, full stall, then push-with-pop when full
    for (int k = 1; k <= 4; k++) issue(5'(k), 1, 0);
    clr(); iss_valid = 1; iss_rd = 9; iss_rd_wen = 1; go();
    clr(); iss_valid = 1; iss_rd = 9; iss_rd_wen = 1; wb_valid = 1; go();
    clr(); go();
    drain();

    // CSR writer (CSRRW, then ECALL) blocks a CSR reader until retire
    for (int r = 0; r < 2; r++) begin
      issue(5'(r + 3), r == 0, 1);
      for (int k = 0; k < 2; k++) begin clr(); iss_valid = 1; iss_csr_rd = 1; go(); end
      clr(); iss_valid = 1; iss_csr_rd = 1; wb_valid = 1; go();
      drain();
    end

    // Underflow is sticky; flush blocks a clean offer without pushing
    clr(); wb_valid = 1; go();
    clr(); go();
    clr(); iss_valid = 1; flush = 1; go();
    clr(); go();

    // Reset between edges with 3 in flight, then perf accumulation
    for (int k = 1; k <= 3; k++) issue(5'(k + 10), 1, 0);
    clr(); reset = 1; go();
    reset = 0; clr(); iss_valid = 1; iss_rs1 = 11; iss_rs1_en = 1; go();
    drain();
    issue(5'd5, 1, 0);
    for (int k = 0; k < 10; k++) begin clr(); iss_valid = 1; iss_rs1 = 5; iss_rs1_en = 1; go(); end
    clr(); go();
    drain();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      clr();
      reset       = ($urandom_range(0, 149) == 0);
      iss_valid   = ($urandom_range(0, 3) != 0);
      iss_rs1     = 5'($urandom_range(0, 7));
      iss_rs2     = 5'($urandom_range(0, 7));
      iss_rs1_en  = 1'($urandom_range(0, 1));
      iss_rs2_en  = 1'($urandom_range(0, 1));
      iss_rd      = 5'($urandom_range(0, 7));
      iss_rd_wen  = ($urandom_range(0, 3) != 0);
      iss_csr_rd  = ($urandom_range(0, 5) == 0);
      iss_csr_wen = ($urandom_range(0, 7) == 0);
      wb_valid    = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      go();
    end
    reset = 0; clr(); go();

    repeat (2) @(negedge clock);
    #5;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24090012_issue_scoreboard.md
YSYX_24090012_ISSUE_SCOREBOARD -- requirements
Module: ysyx_24090012_issue_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight tracking FIFO entries (power of two, 2..8).
REQ-002 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port iss_valid  in  1  decoded instruction offered for issue.
REQ-005 SHALL have port iss_ready  out  1  issue permitted this cycle.
REQ-006 SHALL have ports iss_rs1, iss_rs2  in  5 each  source register indices.
REQ-007 SHALL have ports iss_rs1_en, iss_rs2_en  in  1 each  source actually read.
REQ-008 SHALL have ports iss_rd  in  5, iss_rd_wen  in  1  destination and its write enable.
REQ-009 SHALL have ports iss_csr_rd, iss_csr_wen  in  1 each  instruction reads / writes any CSR (ECALL counts as writer).
REQ-010 SHALL have port wb_valid  in  1  oldest in-flight instruction retired by writeback.
REQ-011 SHALL have port flush  in  1  control hazard: drop current issue offer.
REQ-012 SHALL have ports inflight_cnt  out  $clog2(DEPTH)+1, stall_data  out  1, stall_full  out  1, wb_underflow  out  1 (sticky).
REQ-013 SHALL have ports perf_data_stalls, perf_full_stalls  out  32 each.

Function
REQ-014 SHALL hold a FIFO of DEPTH entries {rd, rd_wen, csr_wen}, written on issue fire (iss_valid && iss_ready), popped on wb_valid; retirement is in order.
REQ-015 SHALL flag GPR hazard when any live entry has rd_wen=1, rd!=0, rd equal to an enabled source index.
REQ-016 SHALL flag CSR hazard when iss_csr_rd or iss_csr_wen is set and any live entry has csr_wen=1.
REQ-017 SHALL exclude the head entry from hazard search in a cycle with wb_valid=1 (same-cycle retire releases).
REQ-018 SHALL assert stall_full when count==DEPTH and wb_valid=0; a pop in the same cycle allows a push when full.
REQ-019 SHALL compute iss_ready = !flush && !stall_full && !hazard, purely combinational; stall_data = iss_valid && hazard && !flush.
REQ-020 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-021 SHALL wrap read/write pointers modulo DEPTH.
REQ-022 SHALL, on wb_valid with count==0, ignore the pop, keep count 0, set wb_underflow until reset.
REQ-023 SHALL not remove live entries on flush; only the current offer is blocked.
REQ-024 SHALL drive inflight_cnt from the registered count (0..DEPTH).

Reset
REQ-025 SHALL, while reset=1, force count=0, pointers=0, entries invalid, wb_underflow=0, perf counters 0, regardless of clock.
REQ-026 SHALL, with reset asserted mid-operation, discard all in-flight entries; iss_ready=1 after release with iss_valid hazard-free inputs.

Configuration
REQ-027 SHALL compile stall performance counters only when YSYX_24090012_SCB_PERF_EN is defined: perf_data_stalls increments each cycle stall_data=1, perf_full_stalls each cycle iss_valid && stall_full && !flush, both wrap at 2^32.
REQ-028 SHALL, without YSYX_24090012_SCB_PERF_EN, tie both perf outputs to 0 with no counter registers.

Verification
REQ-029 SHALL cover: issue rd=5 wen=1, then offer rs1=5 rs1_en=1 -> iss_ready=0, stall_data=1 until wb_valid, iss_ready=1 in the wb_valid cycle.
REQ-030 SHALL cover: issue rd=0 wen=1, then rs1=0 -> no stall; rs2=7 with rs2_en=0 against in-flight rd=7 -> no stall.
REQ-031 SHALL cover: DEPTH=4, four independent issues, no wb -> inflight_cnt=4, stall_full=1; fifth with wb_valid same cycle -> fires, count stays 4.
REQ-032 SHALL cover: issue CSRRW (csr_wen=1) then CSRRS offer -> stalled until retire; ECALL then CSR read -> same.
REQ-033 SHALL cover: wb_valid with empty FIFO -> count 0, wb_underflow=1 held; flush=1 with clean offer -> iss_ready=0, no push.
REQ-034 SHALL cover: reset asserted between clock edges with 3 in flight -> inflight_cnt=0 immediately; with PERF_EN, 10 hazard cycles -> perf_data_stalls=10.
